// File: rtl/output_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// output_port_arbiter_pkg
//   Shared definitions for the leaf output port arbiter:
//     - PACKET_BITS_DEF : default network packet width
//     - idx_bits()      : index width for N ports, $clog2(N) with a minimum of 1
//     - IDLE / BURST    : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package output_port_arbiter_pkg;

   localparam int PACKET_BITS_DEF = 97;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] BURST = 1'b1;

   function automatic int idx_bits(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/output_port_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Scans the request vector starting at
//   'start' and wrapping modulo N; 'start - 1' is therefore checked last.
//   Shared with the input-side arbiter.
//
// Ports:
//   req   in  N      request vector (one bit per port)
//   start in  IDX_W  first index to examine
//   idx   out IDX_W  first requesting index in scan order (start when none)
//   any   out 1      at least one request is present
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N     = 7,
   parameter int IDX_W = 3
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Walk the scan order backwards so the last hit written is the first
   // requester in round-robin order; no priority flag is needed.
   always_comb begin
      int p;
      p   = 0;
      idx = start;
      any = |req;
      for (int k = N - 1; k >= 0; k--) begin
         p = int'(start) + k;
         if (p >= N) p = p - N;
         if (req[p]) idx = IDX_W'(p);
      end
   end

endmodule

// File: rtl/output_port_arbiter.sv
// ---------------------------------------------------------------------------
// output_port_arbiter
//   Shares one leaf-to-network packet path between the output ports of a
//   leaf cluster. Each port is a first-word-fall-through FIFO; the arbiter
//   pops the chosen port with a one-cycle rd_en_sel pulse and registers the
//   head packet into a single valid/ready output stage. Round-robin with a
//   bounded burst of BURST_LEN packets per port.
//
// Ports:
//   clk           in  1                          network clock
//   reset         in  1                          async, active-high
//   empty         in  NUM_OUT_PORTS              per-port FIFO empty flag
//   internal_out  in  PACKET_BITS*NUM_OUT_PORTS  per-port head packet
//   rd_en_sel     out NUM_OUT_PORTS              one-hot pop strobe (comb.)
//   out_packet    out PACKET_BITS                registered packet
//   out_vld       out 1                          out_packet is valid
//   out_rdy       in  1                          downstream accepts
//   out_port_idx  out IDX_BITS                   source port of out_packet
//   stall_cnt     out 32                         only with
//                                                OUTPUT_PORT_ARBITER_PERF_CNT_EN:
//                                                saturating count of cycles
//                                                with out_vld=1, out_rdy=0
// ---------------------------------------------------------------------------
module output_port_arbiter
   import output_port_arbiter_pkg::*;
#(
   parameter  int PACKET_BITS   = PACKET_BITS_DEF,
   parameter  int NUM_OUT_PORTS = 7,
   parameter  int BURST_LEN     = 4,
   localparam int IDX_BITS      = idx_bits(NUM_OUT_PORTS)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_OUT_PORTS-1:0]           empty,
   input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0] internal_out,
   output logic [NUM_OUT_PORTS-1:0]           rd_en_sel,
   output logic [PACKET_BITS-1:0]             out_packet,
   output logic                               out_vld,
   input  logic                               out_rdy,
   output logic [IDX_BITS-1:0]                out_port_idx
`ifdef OUTPUT_PORT_ARBITER_PERF_CNT_EN
   ,
   output logic [31:0]                        stall_cnt
`endif
);

   localparam int                  CNT_W     = $clog2(BURST_LEN + 1);
   localparam logic [IDX_BITS-1:0] LAST_PORT = IDX_BITS'(NUM_OUT_PORTS - 1);
   localparam logic [CNT_W-1:0]    BURST_MAX = CNT_W'(BURST_LEN);

   logic [0:0]             state_p1;
   logic [IDX_BITS-1:0]    cur_p1;
   logic [CNT_W-1:0]       burst_cnt_p1;
   logic                   vld_p1;
   logic [PACKET_BITS-1:0] pkt_p1;
   logic [IDX_BITS-1:0]    idx_p1;

   logic [IDX_BITS-1:0]    start_idx;
   logic [IDX_BITS-1:0]    pick_idx;
   logic [IDX_BITS-1:0]    chosen;
   logic                   any_req;
   logic                   load_ok;
   logic                   load;
   logic                   stay;

   // ---- stage p0: port choice and pop strobe --------------------------------
   assign start_idx = (cur_p1 == LAST_PORT) ? '0 : cur_p1 + 1'b1;

   rr_pick #(
      .N     (NUM_OUT_PORTS),
      .IDX_W (IDX_BITS)
   ) u_rr_pick (
      .req   (~empty),
      .start (start_idx),
      .idx   (pick_idx),
      .any   (any_req)
   );

   assign load_ok = !vld_p1 || out_rdy;
   assign load    = load_ok && any_req;
   assign stay    = (state_p1 == BURST) && !empty[cur_p1] && (burst_cnt_p1 < BURST_MAX);
   assign chosen  = stay ? cur_p1 : pick_idx;

   // Gated by reset so no FIFO is popped while the output stage is held clear.
   always_comb begin
      rd_en_sel = '0;
      if (load && !reset) rd_en_sel[chosen] = 1'b1;
   end

   // ---- stage p1: output register and burst FSM ------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_p1     <= IDLE;
         cur_p1       <= LAST_PORT;
         burst_cnt_p1 <= '0;
         vld_p1       <= 1'b0;
         pkt_p1       <= '0;
         idx_p1       <= '0;
      end else if (load) begin
         vld_p1   <= 1'b1;
         pkt_p1   <= internal_out[int'(chosen)*PACKET_BITS +: PACKET_BITS];
         idx_p1   <= chosen;
         state_p1 <= BURST;
         if (state_p1 == BURST && chosen == cur_p1) begin
            if (burst_cnt_p1 != BURST_MAX) burst_cnt_p1 <= burst_cnt_p1 + 1'b1;
         end else begin
            cur_p1       <= chosen;
            burst_cnt_p1 <= CNT_W'(1);
         end
      end else if (load_ok) begin
         // Nothing to send: drop valid and idle, keeping cur for fairness.
         vld_p1   <= 1'b0;
         state_p1 <= IDLE;
      end
   end

   assign out_vld      = vld_p1;
   assign out_packet   = pkt_p1;
   assign out_port_idx = idx_p1;

`ifdef OUTPUT_PORT_ARBITER_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (vld_p1 && !out_rdy && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_output_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_output_port_arbiter
//   Directed bench for output_port_arbiter. A small FIFO occupancy model
//   (cnt/seq per port) feeds empty/internal_out; pops follow rd_en_sel.
//   A second instance with BURST_LEN=1 exercises pure round-robin.
// ---------------------------------------------------------------------------
module tb_output_port_arbiter;

   localparam int PB = 97;
   localparam int NP = 7;

   logic          clk;
   logic          reset;
   logic          rst_rr;
   logic [NP-1:0] empty;
   logic [PB*NP-1:0] internal_out;
   logic [NP-1:0] rd_en_sel;
   logic [PB-1:0] out_packet;
   logic          out_vld;
   logic          out_rdy;
   logic [2:0]    out_port_idx;

   logic [NP-1:0]    empty_rr;
   logic [PB*NP-1:0] internal_out_rr;
   logic [NP-1:0]    rd_en_sel_rr;
   logic [PB-1:0]    out_packet_rr;
   logic             out_vld_rr;
   logic             out_rdy_rr;
   logic [2:0]       out_port_idx_rr;

`ifdef OUTPUT_PORT_ARBITER_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] stall_cnt_rr;
`endif

   int cnt [NP];
   int seq [NP];
   int n_chk;
   int n_err;

   output_port_arbiter #(
      .PACKET_BITS   (PB),
      .NUM_OUT_PORTS (NP),
      .BURST_LEN     (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .empty        (empty),
      .internal_out (internal_out),
      .rd_en_sel    (rd_en_sel),
      .out_packet   (out_packet),
      .out_vld      (out_vld),
      .out_rdy      (out_rdy),
      .out_port_idx (out_port_idx)
`ifdef OUTPUT_PORT_ARBITER_PERF_CNT_EN
      ,
      .stall_cnt    (stall_cnt)
`endif
   );

   output_port_arbiter #(
      .PACKET_BITS   (PB),
      .NUM_OUT_PORTS (NP),
      .BURST_LEN     (1)
   ) dut_rr (
      .clk          (clk),
      .reset        (rst_rr),
      .empty        (empty_rr),
      .internal_out (internal_out_rr),
      .rd_en_sel    (rd_en_sel_rr),
      .out_packet   (out_packet_rr),
      .out_vld      (out_vld_rr),
      .out_rdy      (out_rdy_rr),
      .out_port_idx (out_port_idx_rr)
`ifdef OUTPUT_PORT_ARBITER_PERF_CNT_EN
      ,
      .stall_cnt    (stall_cnt_rr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [PB-1:0] pkt(input int i, input int s);
      return PB'(i * 256 + s);
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present FIFO state on the DUT inputs and let combinational logic settle.
   task automatic settle();
      for (int i = 0; i < NP; i++) begin
         empty[i] = (cnt[i] == 0);
         internal_out[i*PB +: PB] = pkt(i, seq[i]);
      end
      #1;
   endtask

   // One clock: pops taken on this edge are those strobed just before it.
   task automatic tick();
      logic [NP-1:0] pop;
      pop = rd_en_sel;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
         if (pop[i] && cnt[i] > 0) begin
            cnt[i]--;
            seq[i]++;
         end
      end
      settle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < NP; i++) begin
         cnt[i] = 0;
         seq[i] = 0;
      end
      settle();
      tick();
      reset = 1'b0;
      settle();
   endtask

   initial begin
      n_chk   = 0;
      n_err   = 0;
      reset   = 1'b1;
      rst_rr  = 1'b1;
      out_rdy = 1'b0;
      out_rdy_rr = 1'b1;
      empty_rr   = '0;
      for (int i = 0; i < NP; i++) begin
         cnt[i] = 0;
         seq[i] = 0;
         internal_out_rr[i*PB +: PB] = pkt(i, 0);
      end
      @(negedge clk);
      settle();
      tick();

      // Reset state
      chk("rst_vld", 128'(out_vld), 128'(0));
      chk("rst_pkt", 128'(out_packet), 128'(0));
      chk("rst_idx", 128'(out_port_idx), 128'(0));
      chk("rst_rd", 128'(rd_en_sel), 128'(0));
      reset = 1'b0;
      settle();
      chk("idle_rd", 128'(rd_en_sel), 128'(0));

      // Burst of 4 from port 0, then rotate to port 2
      cnt[0] = 8; cnt[2] = 2; cnt[5] = 1;
      out_rdy = 1'b1;
      settle();
      chk("t1_rd0", 128'(rd_en_sel), 128'h01);
      tick();
      for (int k = 1; k <= 3; k++) begin
         chk("t1_vld", 128'(out_vld), 128'(1));
         chk("t1_idx", 128'(out_port_idx), 128'(0));
         chk("t1_pkt", 128'(out_packet), 128'(pkt(0, k - 1)));
         chk("t1_rd", 128'(rd_en_sel), 128'h01);
         tick();
      end
      chk("t1_pkt3", 128'(out_packet), 128'(pkt(0, 3)));
      chk("t1_idx3", 128'(out_port_idx), 128'(0));
      chk("t1_rot_rd", 128'(rd_en_sel), 128'h04);
      tick();
      chk("t1_rot_idx", 128'(out_port_idx), 128'(2));
      chk("t1_rot_pkt", 128'(out_packet), 128'(pkt(2, 0)));

      // Backpressure for 5 cycles
      out_rdy = 1'b0;
      settle();
      chk("bp_rd_first", 128'(rd_en_sel), 128'(0));
      for (int s = 0; s < 5; s++) begin
         tick();
         chk("bp_rd", 128'(rd_en_sel), 128'(0));
         chk("bp_vld", 128'(out_vld), 128'(1));
         chk("bp_pkt", 128'(out_packet), 128'(pkt(2, 0)));
      end
`ifdef OUTPUT_PORT_ARBITER_PERF_CNT_EN
      chk("bp_stall_cnt", 128'(stall_cnt), 128'(5));
`endif
      out_rdy = 1'b1;
      settle();
      chk("bp_release_rd", 128'(rd_en_sel), 128'h04);
      tick();
      chk("bp_release_pkt", 128'(out_packet), 128'(pkt(2, 1)));
      chk("bp_release_idx", 128'(out_port_idx), 128'(2));

      // Pure round-robin, BURST_LEN=1, all ports always non-empty
      rst_rr = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("rr_vld", 128'(out_vld_rr), 128'(1));
         chk("rr_idx", 128'(out_port_idx_rr), 128'(k % NP));
      end

      // Port 3 drains mid-burst: next grant goes to 6, not 0
      do_reset();
      cnt[3] = 2;
      settle();
      chk("t4_rd_a", 128'(rd_en_sel), 128'h08);
      tick();
      cnt[6] = 1; cnt[0] = 3;
      settle();
      chk("t4_rd_b", 128'(rd_en_sel), 128'h08);
      chk("t4_idx_a", 128'(out_port_idx), 128'(3));
      tick();
      chk("t4_rd_c", 128'(rd_en_sel), 128'h40);
      chk("t4_pkt_b", 128'(out_packet), 128'(pkt(3, 1)));
      tick();
      chk("t4_idx_c", 128'(out_port_idx), 128'(6));
      chk("t4_pkt_c", 128'(out_packet), 128'(pkt(6, 0)));

      // All empty -> idle; port 1 wakes up
      cnt[0] = 0;
      settle();
      chk("t5_rd_none", 128'(rd_en_sel), 128'(0));
      tick();
      chk("t5_vld_off", 128'(out_vld), 128'(0));
      cnt[1] = 1;
      settle();
      chk("t5_rd_wake", 128'(rd_en_sel), 128'h02);
      tick();
      chk("t5_vld_on", 128'(out_vld), 128'(1));
      chk("t5_idx", 128'(out_port_idx), 128'(1));
      chk("t5_pkt", 128'(out_packet), 128'(pkt(1, 0)));

      // Asynchronous reset while a packet is held
      cnt[0] = 1; cnt[4] = 1;
      settle();
      chk("t6_rd_pre", 128'(rd_en_sel), 128'h10);
      reset = 1'b1;
      #1;
      chk("t6_vld", 128'(out_vld), 128'(0));
      chk("t6_pkt", 128'(out_packet), 128'(0));
      chk("t6_idx", 128'(out_port_idx), 128'(0));
      chk("t6_rd", 128'(rd_en_sel), 128'(0));
      tick();
      reset = 1'b0;
      settle();
      chk("t6_restart_rd", 128'(rd_en_sel), 128'h01);
      tick();
      chk("t6_restart_idx", 128'(out_port_idx), 128'(0));
      chk("t6_restart_pkt", 128'(out_packet), 128'(pkt(0, 0)));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
